// File: rtl/nanosoc_arbiter_rr4.sv
// nanosoc_arbiter_rr4
// Round-robin, burst-aware arbiter for a shared AHB target output stage
// serving up to four bus-switch input ports.
//
// The grant is held while a fixed-length burst (INCR4/8/16, WRAP4/8/16) is
// in flight, while a BUSY beat is forwarded, and while the forwarded port
// asserts a lock. Ports whose PORT_MASK bit is clear never win.
//
// Parameters:
//   PORT_MASK   bit i set = input port i is connected
//   RESET_PORT  port index on addr_in_port after reset; also the initial
//               round-robin pointer (must be a connected port)
//
// Ports:
//   HCLK          in   AHB system clock
//   HRESET        in   synchronous active-high reset
//   req_port[3:0] in   per-port request
//   HREADYM       in   output-stage HREADY; state advances only when 1
//   HSELM         in   HSEL of the forwarded port
//   HTRANSM[1:0]  in   HTRANS of the forwarded port
//   HBURSTM[2:0]  in   HBURST of the forwarded port
//   HMASTLOCKM    in   lock of the forwarded port
//   addr_in_port  out  granted port index (registered)
//   no_port       out  1 = no port granted (registered)
module nanosoc_arbiter_rr4 #(
  parameter logic [3:0] PORT_MASK  = 4'b1111,
  parameter logic [1:0] RESET_PORT = 2'd0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] req_port,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [1:0] addr_in_port,
  output logic       no_port
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [1:0] r_addr_in_port;
  logic       r_no_port;
  logic [3:0] r_burst_cnt;
  logic [1:0] r_rr_ptr;

  logic [3:0] w_burst_cnt_nxt;
  logic       w_hold;
  logic [3:0] w_valid;
  logic       w_found;
  logic [1:0] w_winner;
  logic [1:0] w_idx;

  // Remaining SEQ beats of the fixed-length burst being forwarded.
  always_comb begin
    w_burst_cnt_nxt = r_burst_cnt;
    if (HSELM && (HTRANSM == TRANS_NONSEQ)) begin
      unique case (HBURSTM)
        3'b010, 3'b011: w_burst_cnt_nxt = 4'd3;
        3'b100, 3'b101: w_burst_cnt_nxt = 4'd7;
        3'b110, 3'b111: w_burst_cnt_nxt = 4'd15;
        default:        w_burst_cnt_nxt = 4'd0;  // SINGLE and INCR
      endcase
    end else if (!HSELM || (HTRANSM == TRANS_IDLE)) begin
      // An IDLE or deselect ends the burst early.
      w_burst_cnt_nxt = 4'd0;
    end else if ((HTRANSM == TRANS_SEQ) && (r_burst_cnt != 4'd0)) begin
      w_burst_cnt_nxt = r_burst_cnt - 4'd1;
    end
  end

  // The hold decision uses the freshly loaded count, so a NONSEQ that opens
  // a fixed-length burst blocks rearbitration on the same edge.
  assign w_hold = HMASTLOCKM || (w_burst_cnt_nxt != 4'd0) ||
                  ((HTRANSM == TRANS_BUSY) && HSELM);

  assign w_valid = req_port & PORT_MASK;

  // Cyclic search starting one past the last winner; the last winner
  // itself is visited last, so a lone requester is regranted.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && w_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr_in_port <= RESET_PORT;
      r_no_port      <= 1'b1;
      r_burst_cnt    <= 4'd0;
      r_rr_ptr       <= RESET_PORT;
    end else if (HREADYM) begin
      r_burst_cnt <= w_burst_cnt_nxt;
      if (!w_hold) begin
        if (w_found) begin
          r_addr_in_port <= w_winner;
          r_no_port      <= 1'b0;
          r_rr_ptr       <= w_winner;
        end else begin
          r_no_port <= 1'b1;
        end
      end
    end
  end

  assign addr_in_port = r_addr_in_port;
  assign no_port      = r_no_port;

endmodule
